// File: rtl/fe25519_pkg.sv
// Shared GF(2^255-19) types: 10-limb radix-2^25.5 element, op descriptor, inversion chain ROM.
// Used by fe_mul and fe25519_invert (FE_INVERT_PIPE_EN selects the 2-cycle multiply in those files).
package fe25519_pkg;

  localparam int FE_W      = 320;
  localparam int LIMBS     = 10;
  localparam int LIMB_W    = 32;
  localparam int EVEN_BITS = 26;
  localparam int ODD_BITS  = 25;
  localparam int ACC_W     = 64;
  localparam int INV_OPS   = 265;
  localparam int OP_IDX_W  = 9;

  typedef logic signed [LIMB_W-1:0] limb_t;
  typedef limb_t [LIMBS-1:0]        fe_t;
  typedef logic signed [ACC_W-1:0]  wide_t;
  typedef wide_t [LIMBS-1:0]        acc_t;

  typedef enum logic [2:0] {R_Z, R_T0, R_T1, R_T2, R_T3, R_OUT} reg_sel_t;

  typedef struct packed {
    reg_sel_t dst;
    reg_sel_t src_a;
    reg_sel_t src_b;
  } op_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  function automatic op_t mk_op(input reg_sel_t d, input reg_sel_t a, input reg_sel_t b);
    op_t o;
    o.dst   = d;
    o.src_a = a;
    o.src_b = b;
    return o;
  endfunction

  // z^(p-2) addition chain, one entry per op; squaring runs are ranges of identical entries.
  function automatic op_t inv_op(input int k);
    op_t o;
    if      (k == 0)   o = mk_op(R_T0,  R_Z,  R_Z);
    else if (k == 1)   o = mk_op(R_T1,  R_T0, R_T0);
    else if (k == 2)   o = mk_op(R_T1,  R_T1, R_T1);
    else if (k == 3)   o = mk_op(R_T1,  R_Z,  R_T1);
    else if (k == 4)   o = mk_op(R_T0,  R_T0, R_T1);
    else if (k == 5)   o = mk_op(R_T2,  R_T0, R_T0);
    else if (k == 6)   o = mk_op(R_T1,  R_T1, R_T2);
    else if (k == 7)   o = mk_op(R_T2,  R_T1, R_T1);
    else if (k <= 11)  o = mk_op(R_T2,  R_T2, R_T2);
    else if (k == 12)  o = mk_op(R_T1,  R_T2, R_T1);
    else if (k == 13)  o = mk_op(R_T2,  R_T1, R_T1);
    else if (k <= 22)  o = mk_op(R_T2,  R_T2, R_T2);
    else if (k == 23)  o = mk_op(R_T2,  R_T2, R_T1);
    else if (k == 24)  o = mk_op(R_T3,  R_T2, R_T2);
    else if (k <= 43)  o = mk_op(R_T3,  R_T3, R_T3);
    else if (k == 44)  o = mk_op(R_T2,  R_T3, R_T2);
    else if (k <= 54)  o = mk_op(R_T2,  R_T2, R_T2);
    else if (k == 55)  o = mk_op(R_T1,  R_T2, R_T1);
    else if (k == 56)  o = mk_op(R_T2,  R_T1, R_T1);
    else if (k <= 105) o = mk_op(R_T2,  R_T2, R_T2);
    else if (k == 106) o = mk_op(R_T2,  R_T2, R_T1);
    else if (k == 107) o = mk_op(R_T3,  R_T2, R_T2);
    else if (k <= 206) o = mk_op(R_T3,  R_T3, R_T3);
    else if (k == 207) o = mk_op(R_T2,  R_T3, R_T2);
    else if (k <= 257) o = mk_op(R_T2,  R_T2, R_T2);
    else if (k == 258) o = mk_op(R_T1,  R_T2, R_T1);
    else if (k <= 263) o = mk_op(R_T1,  R_T1, R_T1);
    else               o = mk_op(R_OUT, R_T1, R_T0);
    return o;
  endfunction

endpackage

// File: rtl/fe_mul.sv
// Field multiply p = a*b in 10-limb form: schoolbook accumulate then ref10 carry chain.
// Combinational by default; FE_INVERT_PIPE_EN registers the accumulators (1-cycle latency).
module fe_mul
  import fe25519_pkg::*;
(
`ifdef FE_INVERT_PIPE_EN
  input  logic            clk,
  input  logic            rst,
`endif
  input  logic [FE_W-1:0] a,
  input  logic [FE_W-1:0] b,
  output logic [FE_W-1:0] p
);

  localparam int CARRY_STEPS = 12;
  localparam int CARRY_SEQ [CARRY_STEPS] = '{0, 4, 1, 5, 2, 6, 3, 7, 4, 8, 9, 0};

  // Odd*odd terms doubled (half-bit radix), wrapped terms scaled by 19 (2^255 = 19 mod p).
  function automatic acc_t accumulate(input fe_t f, input fe_t g);
    acc_t  h;
    wide_t fi;
    wide_t gj;
    h = '0;
    for (int i = 0; i < LIMBS; i++) begin
      for (int j = 0; j < LIMBS; j++) begin
        fi = {{(ACC_W-LIMB_W){f[i][LIMB_W-1]}}, f[i]};
        gj = {{(ACC_W-LIMB_W){g[j][LIMB_W-1]}}, g[j]};
        if ((i % 2 == 1) && (j % 2 == 1)) fi = fi <<< 1;
        if (i + j >= LIMBS) gj = gj * 64'sd19;
        h[(i + j) % LIMBS] = h[(i + j) % LIMBS] + fi * gj;
      end
    end
    return h;
  endfunction

  function automatic fe_t carry_chain(input acc_t hin);
    wide_t h [LIMBS];
    wide_t c;
    fe_t   r;
    int    s;
    int    sh;
    for (int i = 0; i < LIMBS; i++) h[i] = hin[i];
    for (int k = 0; k < CARRY_STEPS; k++) begin
      s  = CARRY_SEQ[k];
      sh = (s % 2 == 0) ? EVEN_BITS : ODD_BITS;
      c  = (h[s] + (64'sd1 <<< (sh - 1))) >>> sh;
      if (s == LIMBS - 1) h[0] = h[0] + c * 64'sd19;
      else                h[s + 1] = h[s + 1] + c;
      h[s] = h[s] - (c <<< sh);
    end
    for (int i = 0; i < LIMBS; i++) r[i] = h[i][LIMB_W-1:0];
    return r;
  endfunction

`ifdef FE_INVERT_PIPE_EN
  acc_t acc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) acc_q <= '0;
    else      acc_q <= accumulate(a, b);
  end

  assign p = carry_chain(acc_q);
`else
  assign p = carry_chain(accumulate(a, b));
`endif

endmodule

// File: rtl/fe25519_invert.sv
// Field inverse out = z^(p-2): 265-op chain, 265 cycles (530 with FE_INVERT_PIPE_EN); valid ignored while busy.
// done is level-high from the last op until the next start or reset.
module fe25519_invert
  import fe25519_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [FE_W-1:0] z,
  output logic [FE_W-1:0] out,
  input  logic            valid,
  output logic            done
);

  state_t              state;
  state_t              state_nx;
  logic [OP_IDX_W-1:0] op_idx;
  op_t                 op;
  fe_t                 z_r, t0, t1, t2, t3, out_r;
  fe_t                 opnd_a, opnd_b;
  logic [FE_W-1:0]     prod;
  logic                start;
  logic                wr_en;
  logic                last_op;
`ifdef FE_INVERT_PIPE_EN
  logic                phase;
`endif

  function automatic fe_t sel_reg(input reg_sel_t s, input fe_t rz, input fe_t r0,
                                  input fe_t r1, input fe_t r2, input fe_t r3);
    fe_t v;
    case (s)
      R_T0:    v = r0;
      R_T1:    v = r1;
      R_T2:    v = r2;
      R_T3:    v = r3;
      default: v = rz;
    endcase
    return v;
  endfunction

  assign op      = inv_op(int'(op_idx));
  assign last_op = (int'(op_idx) == INV_OPS - 1);
  assign start   = valid && (state != S_RUN);
  assign opnd_a  = sel_reg(op.src_a, z_r, t0, t1, t2, t3);
  assign opnd_b  = sel_reg(op.src_b, z_r, t0, t1, t2, t3);

`ifdef FE_INVERT_PIPE_EN
  // Phase 0 loads the accumulator register, phase 1 retires the op.
  assign wr_en = (state == S_RUN) && phase;

  fe_mul u_mul (
    .clk (clk),
    .rst (rst),
    .a   (opnd_a),
    .b   (opnd_b),
    .p   (prod)
  );
`else
  assign wr_en = (state == S_RUN);

  fe_mul u_mul (
    .a (opnd_a),
    .b (opnd_b),
    .p (prod)
  );
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (valid) state_nx = S_RUN;
      S_RUN:          if (wr_en && last_op) state_nx = S_DONE;
      default:        state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_idx <= '0;
      z_r    <= '0;
      t0     <= '0;
      t1     <= '0;
      t2     <= '0;
      t3     <= '0;
      out_r  <= '0;
`ifdef FE_INVERT_PIPE_EN
      phase  <= 1'b0;
`endif
    end else if (start) begin
      z_r    <= z;
      op_idx <= '0;
`ifdef FE_INVERT_PIPE_EN
      phase  <= 1'b0;
`endif
    end else if (state == S_RUN) begin
`ifdef FE_INVERT_PIPE_EN
      phase <= ~phase;
`endif
      if (wr_en) begin
        case (op.dst)
          R_T0:    t0    <= prod;
          R_T1:    t1    <= prod;
          R_T2:    t2    <= prod;
          R_T3:    t3    <= prod;
          R_OUT:   out_r <= prod;
          default: ;
        endcase
        if (!last_op) op_idx <= op_idx + OP_IDX_W'(1);
      end
    end
  end

  assign out  = out_r;
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_fe25519_invert.sv
// Directed bench for fe25519_invert with a scoreboard queue of expected inverses.
module tb_fe25519_invert;

`ifdef FE_INVERT_PIPE_EN
  localparam int LAT = 530;
`else
  localparam int LAT = 265;
`endif
  localparam int BUDGET = LAT + 64;

  localparam logic [319:0] REF_Z =
    320'h00053a81017f6f0affc217b7fe20238d008e7c68fe44054e0062a67b00a68f5600a2a82fffd1a58d;
  localparam logic [319:0] REF_OUT =
    320'h00a7d731ff3e2b82ffb1b4c001737c3dff6b2a2801b99e9b00e91fa401bc825bff022266ff9caf02;
  localparam logic [319:0] ONE       = 320'h1;
  localparam logic [319:0] ZERO      = 320'h0;
  localparam logic [319:0] MINUS_ONE = 320'hffffffff;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid;
  logic [319:0] z;
  logic [319:0] out;
  logic         done;

  int           checks   = 0;
  int           failures = 0;
  logic [319:0] exp_q [$];

  always #5 clk = ~clk;

  fe25519_invert dut (
    .clk   (clk),
    .rst   (rst),
    .z     (z),
    .out   (out),
    .valid (valid),
    .done  (done)
  );

  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic start(input logic [319:0] zv, input logic [319:0] expv);
    @(negedge clk);
    z     = zv;
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    exp_q.push_back(expv);
    check("done_clear_on_capture", {319'd0, done}, 320'd0);
  endtask

  // Counts edges after capture until done; optionally pulses valid with z=1 at cycle poke_at.
  task automatic run_to_done(input string tag, input int poke_at, input int poke_len);
    int           cyc;
    logic [319:0] expv;
    cyc = 0;
    while (cyc < BUDGET) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == poke_at + poke_len) valid = 1'b0;
      if (cyc == poke_at) begin
        valid = 1'b1;
        z     = ONE;
      end
      if (done) break;
    end
    check({tag, "_latency"}, 320'(cyc), 320'(LAT));
    expv = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    check({tag, "_out"}, out, expv);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b0;
    valid = 1'b0;
    z     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", out, 320'd0);
    check("reset_done", {319'd0, done}, 320'd0);
    @(negedge clk);
    rst = 1'b1;

    start(REF_Z, REF_OUT);
    run_to_done("ref", 0, 0);
    repeat (5) @(posedge clk);
    #1;
    check("ref_hold_done", {319'd0, done}, 320'd1);
    check("ref_hold_out", out, REF_OUT);

    // Restart straight from DONE
    start(ONE, ONE);
    run_to_done("unity", 0, 0);

    start(ZERO, ZERO);
    run_to_done("zero", 0, 0);

    start(MINUS_ONE, MINUS_ONE);
    run_to_done("minus_one", 0, 0);

    start(REF_Z, REF_OUT);
    run_to_done("busy", 99, 1);

    // valid sampled on the edge done rises must be ignored
    start(MINUS_ONE, MINUS_ONE);
    run_to_done("b2b", LAT - 1, 1);
    repeat (3) @(posedge clk);
    #1;
    check("b2b_done_held", {319'd0, done}, 320'd1);
    check("b2b_out_held", out, MINUS_ONE);

    start(REF_Z, REF_OUT);
    repeat (50) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("rst_mid_out", out, 320'd0);
    check("rst_mid_done", {319'd0, done}, 320'd0);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_idle_done", {319'd0, done}, 320'd0);

    start(REF_Z, REF_OUT);
    run_to_done("after_rst", 0, 0);

    check("scoreboard_drained", 320'(exp_q.size()), 320'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
